// File: rtl/code_decode_display.sv
// code_decode_display: queued 3-to-8 decoder feeding the board LEDs and seven-segment digit.
// Entries {en, code} arrive over valid/ready, wait in a small FIFO, and each is shown
// for HOLD cycles. The display keeps the last entry once the queue runs dry.
//
// state | meaning
// IDLE  | nothing being timed; the next queued entry loads on the following edge
// SHOW  | an entry is on the display; hold_q counts its remaining cycles down to 0
module code_decode_display #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_en,
    input  logic [2:0] in_code,
    output logic [7:0] ledr,
    output logic [7:0] seg,
    output logic       disp_valid,
    output logic       busy,
    output logic [7:0] disp_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD - 1);
    localparam logic [AW:0]   FULL_LEVEL  = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    ledr_q, ledr_d;
    logic [7:0]    seg_q, seg_d;
    logic [7:0]    disp_count_q, disp_count_d;
    logic          disp_valid_q, disp_valid_d;
    logic          push, pop;
    logic [3:0]    head;

    // Active-low segment patterns, a..g in bits 7..1, dp off; a blank entry lights nothing.
    function automatic logic [7:0] seg_of(input logic [3:0] e);
        logic [7:0] s;
        s = 8'hFF;
        if (e[3]) begin
            case (e[2:0])
                3'd0:    s = 8'h03;
                3'd1:    s = 8'h9F;
                3'd2:    s = 8'h25;
                3'd3:    s = 8'h0D;
                3'd4:    s = 8'h99;
                3'd5:    s = 8'h49;
                3'd6:    s = 8'h41;
                default: s = 8'h1F;
            endcase
        end
        return s;
    endfunction

    // Handshake, FIFO bookkeeping and the IDLE/SHOW sequencing.
    always_comb begin
        // Ready comes from registered occupancy only, so a same-cycle pop never frees a slot early.
        in_ready     = (count_q != FULL_LEVEL);
        push         = in_valid && in_ready;
        // hold_q is always 0 in IDLE, so one condition covers both load points.
        pop          = (count_q != '0) && ((state_q == IDLE) || (hold_q == '0));
        head         = mem_q[rd_ptr_q];

        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        hold_d       = hold_q;
        ledr_d       = ledr_q;
        seg_d        = seg_q;
        disp_valid_d = disp_valid_q;
        disp_count_d = disp_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (pop) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            ledr_d       = head[3] ? (8'h01 << head[2:0]) : 8'h00;
            seg_d        = seg_of(head);
            disp_valid_d = 1'b1;
            disp_count_d = disp_count_q + 1'b1;
            hold_d       = HOLD_RELOAD;
            state_d      = SHOW;
        end else if (state_q == SHOW) begin
            if (hold_q != '0) begin
                hold_d = hold_q - 1'b1;
            end else begin
                // Queue ran dry: stop timing but leave the last entry on the pins.
                state_d = IDLE;
            end
        end
    end

    // Entry storage; stale contents after reset are unreachable because the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_en, in_code};
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hold_q       <= '0;
            ledr_q       <= 8'h00;
            seg_q        <= 8'hFF;
            disp_valid_q <= 1'b0;
            disp_count_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hold_q       <= hold_d;
            ledr_q       <= ledr_d;
            seg_q        <= seg_d;
            disp_valid_q <= disp_valid_d;
            disp_count_q <= disp_count_d;
        end
    end

    assign ledr       = ledr_q;
    assign seg        = seg_q;
    assign disp_valid = disp_valid_q;
    assign disp_count = disp_count_q;
    assign busy       = (state_q == SHOW);

endmodule
